// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO family.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_pkg;

   localparam int FIFO_DEPTH      = 256;
   localparam int FIFO_DATA_WIDTH = 8;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; the caller gates wr_en so only accepted writes arrive here.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   // Contents are deliberately left unreset so the array can map onto RAM.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Store the accepted write word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with level, almost-full/empty flags and overflow/underflow pulses.
// Latency: write visible after one edge; data_out registered (FWFT=0) or head-of-queue (FWFT=1).
// Backpressure: writes when full and reads when empty are dropped and flagged for one cycle.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int            PW      = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_acc, rd_acc;
   logic                  full_w, empty_w;
   logic [PW-1:0]         level_w;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   // Flags come only from the pointer flops, so they settle right after each
   // edge (and immediately on reset) with no path from wr_en or rd_en.
   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign level_w = wr_ptr_q - rd_ptr_q;

   assign full         = full_w;
   assign empty        = empty_w;
   assign level        = level_w;
   assign almost_full  = (level_w >= AF_LVL);
   assign almost_empty = (level_w <= AE_LVL);
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // Acceptance is judged on the pre-edge flags only: a same-cycle read never
   // frees space for a write, and a same-cycle write never feeds a read.
   always_comb begin
      wr_acc   = wr_en && !full_w;
      rd_acc   = rd_en && !empty_w;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      ovf_d = wr_en && full_w;
      udf_d = rd_en && empty_w;
   end

   // Pointer and error-pulse state; reset discards every held entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rd_data (mem_rd_data)
   );

   if (FWFT == 0) begin : g_reg_out
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      // Capture the word being read; hold otherwise.
      always_comb begin
         dout_d = dout_q;
         if (rd_acc) begin
            dout_d = mem_rd_data;
         end
      end

      // Output register, cleared by reset.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            dout_q <= '0;
         end else begin
            dout_q <= dout_d;
         end
      end

      assign data_out = dout_q;
   end else begin : g_fwft_out
      // Head entry shown directly; forced to zero while empty so reset reads 0.
      assign data_out = empty_w ? '0 : mem_rd_data;
   end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: registered and FWFT instances driven in lockstep against a queue model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_param_sync_fifo;

   localparam int DEPTH = 8;
   localparam int DW    = 8;
   localparam int AW    = 3;

   logic          clk     = 1'b0;
   logic          rstn    = 1'b1;
   logic          wr_en   = 1'b0;
   logic          rd_en   = 1'b0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] r_dout, f_dout;
   logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [AW:0]   r_level, f_level;

   always #5 clk = ~clk;

   param_sync_fifo #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
   ) dut_r (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(r_dout), .full(r_full), .empty(r_empty), .almost_full(r_af),
      .almost_empty(r_ae), .level(r_level), .overflow(r_ovf), .underflow(r_udf)
   );

   param_sync_fifo #(
      .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
      .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
   ) dut_f (
      .clk(clk), .rstn(rstn), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .level(f_level), .overflow(f_ovf), .underflow(f_udf)
   );

   // Reference model: contents as a queue, plus the last word read out.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout;
   logic          m_ovf, m_udf;
   int            n_vec;
   int            n_err;

   typedef struct {
      logic          wr;
      logic [DW-1:0] din;
      logic          rd;
      int            lvl;
      logic          full;
      logic          empty;
      logic          af;
      logic          ae;
      logic          ovf;
      logic          udf;
      logic [DW-1:0] dout;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int sz;
      sz = q.size();
      chk("r_level", 32'(r_level), 32'(sz));
      chk("r_full",  32'(r_full),  32'(sz == DEPTH));
      chk("r_empty", 32'(r_empty), 32'(sz == 0));
      chk("r_af",    32'(r_af),    32'(sz >= 6));
      chk("r_ae",    32'(r_ae),    32'(sz <= 2));
      chk("r_ovf",   32'(r_ovf),   32'(m_ovf));
      chk("r_udf",   32'(r_udf),   32'(m_udf));
      chk("r_dout",  32'(r_dout),  32'(m_dout));
      chk("f_level", 32'(f_level), 32'(sz));
      chk("f_full",  32'(f_full),  32'(sz == DEPTH));
      chk("f_empty", 32'(f_empty), 32'(sz == 0));
      chk("f_af",    32'(f_af),    32'(sz >= 6));
      chk("f_ae",    32'(f_ae),    32'(sz <= 2));
      chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
      chk("f_udf",   32'(f_udf),   32'(m_udf));
      if (sz != 0) begin
         chk("f_dout_head", 32'(f_dout), 32'(q[0]));
      end
   endtask

   // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
      bit wa, ra;
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      wa      = w && (q.size() < DEPTH);
      ra      = r && (q.size() != 0);
      @(posedge clk);
      m_ovf = w && (q.size() == DEPTH);
      m_udf = r && (q.size() == 0);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
      #1;
      check_model();
   endtask

   // Asynchronous reset between edges, checked before any clock edge, then released.
   task automatic do_reset();
      wr_en = 1'b0;
      rd_en = 1'b0;
      rstn  = 1'b0;
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      #1;
      check_model();
      chk("rst_f_dout", 32'(f_dout), 32'h0);
      @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;

      // Fill/drain vectors: 8 writes, one overflowing write, 8 reads, one underflowing read.
      for (int i = 0; i < 18; i++) begin
         tbl[i] = '{wr: 1'b0, din: '0, rd: 1'b0, lvl: 0, full: 1'b0, empty: 1'b0,
                    af: 1'b0, ae: 1'b0, ovf: 1'b0, udf: 1'b0, dout: '0};
         if (i < 8) begin
            tbl[i].wr  = 1'b1;
            tbl[i].din = 8'(i + 1);
            tbl[i].lvl = i + 1;
         end else if (i == 8) begin
            tbl[i].wr  = 1'b1;
            tbl[i].din = 8'h99;
            tbl[i].lvl = 8;
            tbl[i].ovf = 1'b1;
         end else if (i < 17) begin
            tbl[i].rd   = 1'b1;
            tbl[i].lvl  = 16 - i;
            tbl[i].dout = 8'(i - 8);
         end else begin
            tbl[i].rd   = 1'b1;
            tbl[i].lvl  = 0;
            tbl[i].udf  = 1'b1;
            tbl[i].dout = 8'h08;
         end
         tbl[i].full  = (tbl[i].lvl == 8);
         tbl[i].empty = (tbl[i].lvl == 0);
         tbl[i].af    = (tbl[i].lvl >= 6);
         tbl[i].ae    = (tbl[i].lvl <= 2);
      end

      #2;
      do_reset();

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].wr, tbl[i].din, tbl[i].rd);
         chk("tbl_level", 32'(r_level), 32'(tbl[i].lvl));
         chk("tbl_full",  32'(r_full),  32'(tbl[i].full));
         chk("tbl_empty", 32'(r_empty), 32'(tbl[i].empty));
         chk("tbl_af",    32'(r_af),    32'(tbl[i].af));
         chk("tbl_ae",    32'(r_ae),    32'(tbl[i].ae));
         chk("tbl_ovf",   32'(r_ovf),   32'(tbl[i].ovf));
         chk("tbl_udf",   32'(r_udf),   32'(tbl[i].udf));
         chk("tbl_dout",  32'(r_dout),  32'(tbl[i].dout));
      end
      step(1'b0, 8'h00, 1'b0);
      chk("udf_one_cycle", 32'(r_udf), 32'h0);

      // Wrap: write/read pairs walk the pointers past the end of the array.
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 8'(8'h40 + i), 1'b0);
         chk("wrap_level_le1", 32'(r_level <= 1), 32'h1);
         step(1'b0, 8'h00, 1'b1);
         chk("wrap_dout", 32'(r_dout), 32'(8'h40 + i));
      end

      // Full with simultaneous read and write: read wins, write dropped.
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
      step(1'b1, 8'hEE, 1'b1);
      chk("sim_full_ovf",   32'(r_ovf),   32'h1);
      chk("sim_full_level", 32'(r_level), 32'h7);
      chk("sim_full_dout",  32'(r_dout),  32'h70);
      while (q.size() != 0) step(1'b0, 8'h00, 1'b1);

      // Empty with simultaneous read and write: write lands, read dropped.
      step(1'b1, 8'h5A, 1'b1);
      chk("sim_empty_udf",   32'(r_udf),   32'h1);
      chk("sim_empty_level", 32'(r_level), 32'h1);
      chk("sim_empty_fwft",  32'(f_dout),  32'h5A);
      step(1'b0, 8'h00, 1'b1);

      // FWFT: head word appears one cycle after the write, before any read.
      step(1'b1, 8'hA5, 1'b0);
      chk("fwft_dout",  32'(f_dout),  32'hA5);
      chk("fwft_empty", 32'(f_empty), 32'h0);
      step(1'b0, 8'h00, 1'b1);

      // Reset at level 5 with a non-zero registered output.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      chk("pre_rst_level", 32'(r_level), 32'h5);
      do_reset();
      chk("rst_level", 32'(r_level), 32'h0);
      chk("rst_dout",  32'(r_dout),  32'h0);
      step(1'b1, 8'h33, 1'b1);
      chk("post_rst_udf",   32'(r_udf),   32'h1);
      chk("post_rst_level", 32'(r_level), 32'h1);

      // Randomised phases with varying write/read bias and occasional resets.
      for (int ph = 0; ph < 12; ph++) begin
         int wp;
         wp = int'($urandom_range(10, 90));
         for (int c = 0; c < 250; c++) begin
            step(int'($urandom_range(0, 99)) < wp, 8'($urandom),
                 int'($urandom_range(0, 99)) < (100 - wp));
            if ($urandom_range(0, 399) == 0) do_reset();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
